// File: rtl/cpu_microseq_pkg.sv
// Shared constants for the CPU control unit: state codes, jump opcodes,
// instruction field positions and the control-line bundle type.
package cpu_microseq_pkg;

    // State codes produced by the control unit's cycle decoder
    typedef enum logic [3:0] {
        ST_FETCH_PC   = 4'd0,
        ST_FETCH_INST = 4'd1,
        ST_HALT       = 4'd2,
        ST_JUMP       = 4'd3,
        ST_OUT_A      = 4'd4,
        ST_ALU_OP     = 4'd5,
        ST_NEXT       = 4'd6,
        ST_MOV_FETCH  = 4'd7,
        ST_MOV_LOAD   = 4'd8,
        ST_MOV_STORE  = 4'd9,
        ST_LDI        = 4'd10
    } state_t;

    // Conditional / unconditional jump opcodes
    localparam logic [7:0] OP_JMP = 8'h18;
    localparam logic [7:0] OP_JEZ = 8'h19;
    localparam logic [7:0] OP_JNZ = 8'h1A;

    // Field layout: MOV is 01dddsss, ALU is 10ooosss, LDI carries reg in [2:0]
    localparam int unsigned FIELD_W     = 3;
    localparam int unsigned SRC_LSB     = 0;
    localparam int unsigned DST_LSB     = 3;
    localparam int unsigned ALU_FN_LSB  = 3;

    // Register-file codes
    localparam logic [FIELD_W-1:0] REG_A   = 3'b000;
    localparam logic [FIELD_W-1:0] REG_MEM = 3'b111;

    // Single-bit datapath control lines
    typedef struct packed {
        logic pc_inc;
        logic pc_out;
        logic pc_load;
        logic mar_load;
        logic ram_out;
        logic ram_load;
        logic ir_load;
        logic reg_out;
        logic reg_load;
        logic alu_out;
        logic out_load;
    } ctrl_t;

endpackage

// File: rtl/cpu_microseq_jump_cond.sv
// Jump condition evaluator: decides whether a jump opcode is taken
// given the latched zero flag. Non-jump opcodes are never taken.
module cpu_jump_cond
    import cpu_microseq_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic       flag_zero,
    output logic       taken
);

    // Condition select by opcode
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_JEZ:  taken = flag_zero;
            OP_JNZ:  taken = ~flag_zero;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_microseq.sv
// Microsequencer output stage: decodes state/opcode into the registered
// datapath control bundle, and owns the zero-flag and sticky halt latches.
module cpu_microseq
    import cpu_microseq_pkg::*;
#(
    parameter int unsigned REG_SEL_W = 3,
    parameter int unsigned ALU_OP_W  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           state,
    input  logic [7:0]           opcode,
    input  logic                 alu_zero,
    output logic                 c_pc_inc,
    output logic                 c_pc_out,
    output logic                 c_pc_load,
    output logic                 c_mar_load,
    output logic                 c_ram_out,
    output logic                 c_ram_load,
    output logic                 c_ir_load,
    output logic                 c_reg_out,
    output logic                 c_reg_load,
    output logic [REG_SEL_W-1:0] c_reg_sel,
    output logic                 c_alu_out,
    output logic [ALU_OP_W-1:0]  c_alu_op,
    output logic                 c_out_load,
    output logic                 halted,
    output logic                 reset_cycle,
    output logic                 decode_err
);

    logic                 flag_zero;
    logic                 jump_taken;
    logic [FIELD_W-1:0]   src_field;
    logic [FIELD_W-1:0]   dst_field;
    logic [FIELD_W-1:0]   alu_fn;

    ctrl_t                ctrl_nxt;
    ctrl_t                ctrl_q;
    logic [REG_SEL_W-1:0] sel_nxt;
    logic [ALU_OP_W-1:0]  aluop_nxt;
    logic                 rc_nxt;
    logic                 err_nxt;
    logic                 halted_nxt;
    logic                 flag_nxt;

    assign src_field = opcode[SRC_LSB +: FIELD_W];
    assign dst_field = opcode[DST_LSB +: FIELD_W];
    assign alu_fn    = opcode[ALU_FN_LSB +: FIELD_W];

    cpu_jump_cond u_jump_cond (
        .opcode    (opcode),
        .flag_zero (flag_zero),
        .taken     (jump_taken)
    );

    // Next control bundle from state/opcode; everything stays low once halted
    always_comb begin
        ctrl_nxt  = '0;
        sel_nxt   = '0;
        aluop_nxt = '0;
        rc_nxt    = 1'b0;
        err_nxt   = 1'b0;
        if (!halted) begin
            case (state)
                ST_FETCH_PC, ST_MOV_FETCH: begin
                    ctrl_nxt.pc_out   = 1'b1;
                    ctrl_nxt.mar_load = 1'b1;
                end
                ST_FETCH_INST: begin
                    ctrl_nxt.ram_out = 1'b1;
                    ctrl_nxt.ir_load = 1'b1;
                    ctrl_nxt.pc_inc  = 1'b1;
                end
                ST_HALT: ;
                ST_JUMP: begin
                    if (jump_taken) begin
                        ctrl_nxt.ram_out = 1'b1;
                        ctrl_nxt.pc_load = 1'b1;
                    end else begin
                        ctrl_nxt.pc_inc  = 1'b1;
                    end
                end
                ST_OUT_A: begin
                    ctrl_nxt.reg_out  = 1'b1;
                    ctrl_nxt.out_load = 1'b1;
                    sel_nxt           = REG_SEL_W'(REG_A);
                end
                ST_ALU_OP: begin
                    ctrl_nxt.alu_out  = 1'b1;
                    ctrl_nxt.reg_load = 1'b1;
                    sel_nxt           = REG_SEL_W'(REG_A);
                    aluop_nxt         = ALU_OP_W'(alu_fn);
                end
                ST_NEXT: rc_nxt = 1'b1;
                ST_MOV_LOAD: begin
                    ctrl_nxt.ram_out  = 1'b1;
                    ctrl_nxt.mar_load = 1'b1;
                    ctrl_nxt.pc_inc   = 1'b1;
                end
                // Memory source wins when both fields name memory
                ST_MOV_STORE: begin
                    if (src_field == REG_MEM) begin
                        ctrl_nxt.ram_out  = 1'b1;
                        ctrl_nxt.reg_load = 1'b1;
                        sel_nxt           = REG_SEL_W'(dst_field);
                    end else if (dst_field == REG_MEM) begin
                        ctrl_nxt.reg_out  = 1'b1;
                        ctrl_nxt.ram_load = 1'b1;
                        sel_nxt           = REG_SEL_W'(src_field);
                    end
                end
                ST_LDI: begin
                    ctrl_nxt.ram_out  = 1'b1;
                    ctrl_nxt.reg_load = 1'b1;
                    ctrl_nxt.pc_inc   = 1'b1;
                    sel_nxt           = REG_SEL_W'(src_field);
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // Latch next values: halt is sticky, zero flag only moves in ALU_OP
    always_comb begin
        halted_nxt = halted | (state == ST_HALT);
        flag_nxt   = flag_zero;
        if (!halted && state == ST_ALU_OP) begin
            flag_nxt = alu_zero;
        end
    end

    // Output and status register bank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q      <= '0;
            c_reg_sel   <= '0;
            c_alu_op    <= '0;
            reset_cycle <= 1'b0;
            decode_err  <= 1'b0;
            halted      <= 1'b0;
            flag_zero   <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_nxt;
            c_reg_sel   <= sel_nxt;
            c_alu_op    <= aluop_nxt;
            reset_cycle <= rc_nxt;
            decode_err  <= err_nxt;
            halted      <= halted_nxt;
            flag_zero   <= flag_nxt;
        end
    end

    assign c_pc_inc   = ctrl_q.pc_inc;
    assign c_pc_out   = ctrl_q.pc_out;
    assign c_pc_load  = ctrl_q.pc_load;
    assign c_mar_load = ctrl_q.mar_load;
    assign c_ram_out  = ctrl_q.ram_out;
    assign c_ram_load = ctrl_q.ram_load;
    assign c_ir_load  = ctrl_q.ir_load;
    assign c_reg_out  = ctrl_q.reg_out;
    assign c_reg_load = ctrl_q.reg_load;
    assign c_alu_out  = ctrl_q.alu_out;
    assign c_out_load = ctrl_q.out_load;

endmodule

// File: doc/cpu_microseq.md
Name: cpu_microseq

Overview:
Downstream stage of the CPU control unit: consumes the 4-bit `state` code and the current `opcode`, and drives the registered control-line bundle for the datapath (PC, MAR, RAM, IR, register file, ALU, output latch). It also owns the zero-flag latch used by conditional jumps and the sticky halt latch. It generates the one-clock `reset_cycle` pulse that returns the control unit's cycle counter to 0 after each instruction.

Parameters:
REG_SEL_W, 3, width of register-file select field
ALU_OP_W, 3, width of ALU operation field

Ports:
clk  in  1  system clock, all flops on posedge
reset  in  1  asynchronous active-high reset
state  in  4  state code from the control unit
opcode  in  8  current instruction byte from IR
alu_zero  in  1  ALU zero result, combinational from ALU
c_pc_inc  out  1  increment PC
c_pc_out  out  1  PC drives bus
c_pc_load  out  1  PC loads from bus
c_mar_load  out  1  MAR loads from bus
c_ram_out  out  1  RAM drives bus
c_ram_load  out  1  RAM writes from bus
c_ir_load  out  1  IR loads from bus
c_reg_out  out  1  selected register drives bus
c_reg_load  out  1  selected register loads from bus
c_reg_sel  out  REG_SEL_W  register select
c_alu_out  out  1  ALU result drives bus
c_alu_op  out  ALU_OP_W  ALU operation
c_out_load  out  1  output display latch loads
halted  out  1  sticky halt indicator
reset_cycle  out  1  one-clock pulse to clear cycle counter
decode_err  out  1  one-clock pulse on unknown state code

Behaviour:
- Reset (async, active-high): all outputs 0, flag_zero=0, halted=0; takes effect immediately, including mid-instruction.
- All outputs are registered: decoded from `state`/`opcode` at posedge N, visible after posedge N; latency 1 clock.
- Default every cycle: all controls 0, c_reg_sel=0, c_alu_op=0, reset_cycle=0, decode_err=0.
- State codes (shared constants): FETCH_PC=0, FETCH_INST=1, HALT=2, JUMP=3, OUT_A=4, ALU_OP=5, NEXT=6, MOV_FETCH=7, MOV_LOAD=8, MOV_STORE=9, LDI=10.
- FETCH_PC: c_pc_out, c_mar_load.
- FETCH_INST: c_ram_out, c_ir_load, c_pc_inc.
- HALT: halted<=1 (sticky). While halted, every control, reset_cycle and decode_err stay 0 regardless of state; only reset clears it.
- JUMP: opcode OP_JMP=0x18 is always taken; OP_JEZ=0x19 is taken if flag_zero=1; OP_JNZ=0x1A is taken if flag_zero=0.
  - Taken: c_ram_out, c_pc_load.
  - Not taken: c_pc_inc (skip operand byte).
- LDI: c_ram_out, c_reg_load, c_reg_sel=opcode[2:0], c_pc_inc.
- MOV_FETCH: c_pc_out, c_mar_load.
- MOV_LOAD: c_ram_out, c_mar_load, c_pc_inc.
- MOV_STORE: MOV encoding is 01dddsss.
  - sss==3'b111 (memory source): c_ram_out, c_reg_load, c_reg_sel=ddd.
  - ddd==3'b111 (memory destination): c_reg_out, c_reg_sel=sss, c_ram_load.
  - Both 111: treated as memory source.
- ALU_OP: ALU encoding is 10ooosss. Drives c_alu_out, c_reg_load, c_reg_sel=0 (A), c_alu_op=opcode[5:3]; flag_zero<=alu_zero on the same edge.
- OUT_A: c_reg_out, c_reg_sel=0, c_out_load.
- NEXT: no datapath controls; reset_cycle=1 for exactly one clock. Consecutive NEXT samples give consecutive pulses (no edge detection).
- Codes 11–15: decode_err=1 for one clock, all controls 0.
- flag_zero changes only in ALU_OP or on reset; it is held across all other states and instructions.

Decomposition:
- Shared parameters include (existing): state codes, opcode constants (OP_JMP/JEZ/JNZ), MOV/ALU field positions, memory pseudo-register code 3'b111.
- One natural sub-module: cpu_jump_cond (opcode, flag_zero → taken), a small combinational helper reused by the control unit later.
- The output register bank stays in cpu_microseq.

Test Plan:
- Assert reset mid-ALU_OP with flag_zero previously 1 → next clock all outputs 0, flag_zero 0; a following JEZ (0x19) in JUMP gives c_pc_inc=1, c_pc_load=0.
- state=FETCH_PC then FETCH_INST → after edges: {c_pc_out,c_mar_load}=11, then {c_ram_out,c_ir_load,c_pc_inc}=111.
- opcode=0x80 (ALU op 0, src 0), alu_zero=1, state=ALU_OP; then opcode=0x19, state=JUMP → c_alu_out=1, c_reg_sel=0; then c_pc_load=1, c_ram_out=1. Repeat with 0x1A → c_pc_inc=1 only.
- opcode=0x7A (ddd=111, sss=010), state=MOV_STORE → c_reg_out=1, c_reg_sel=2, c_ram_load=1; opcode=0x4F → c_ram_out=1, c_reg_load=1, c_reg_sel=1.
- state=NEXT for 1 clock → reset_cycle high for exactly 1 clock; state=HALT then NEXT → halted=1, reset_cycle stays 0, all controls 0 until reset.
- state=12 → decode_err single-clock pulse, all controls 0; state=LDI with opcode 0x05 → c_ram_out, c_reg_load, c_pc_inc high, c_reg_sel=5.
